// File: rtl/pipe_adder_nbit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_nbit_pkg
//   Shared EXU definitions for the pipelined carry-propagate adder.
//
//   adder_mode_e : ADD (A + B + carry-in) / SUB (A - B, carry-in forced 1)
//   seg_width()  : width of one pipeline segment, W = N / S
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package pipe_adder_nbit_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_mode_e;

    // Segment width for an N-bit adder split over S stages. Callers must
    // ensure N is an exact multiple of S; the top level rejects other values.
    function automatic int seg_width(input int n, input int s);
        return n / s;
    endfunction

endpackage : pipe_adder_nbit_pkg

// File: rtl/pipe_add_seg.sv
// ---------------------------------------------------------------------------
// pipe_add_seg
//   Combinational W-bit ripple-carry segment used once per pipeline stage.
//
//   Parameters
//     W       : segment width
//     MSB_SEG : 1 when this segment holds bit N-1 of the full word; only then
//               is the signed-overflow term meaningful
//   Ports
//     a, b    in  W  segment operands (b already inverted for subtraction)
//     cin     in  1  carry into bit 0 of the segment
//     s       out W  segment sum
//     cout    out 1  carry out of the segment MSB
//     ovf     out 1  signed overflow of the full word (0 unless MSB_SEG)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_add_seg #(
    parameter int W       = 16,
    parameter bit MSB_SEG = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Plain ripple: the stage's critical path is W bit-cells long no matter
    // how wide the full operand is.
    always_comb begin
        logic carry;
        s     = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            s[i]  = p[i] ^ carry;
            carry = g[i] | (p[i] & carry);
        end
        cout = carry;
    end

    // Overflow: operands share a sign but the result's sign differs.
    if (MSB_SEG) begin : g_ovf
        assign ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end

endmodule : pipe_add_seg

// File: rtl/pipe_adder_nbit.sv
// ---------------------------------------------------------------------------
// pipe_adder_nbit
//   Pipelined N-bit adder/subtractor. The word is split into S segments of
//   W = N/S bits; stage k resolves segment k with the carry registered from
//   stage k-1. Operands are skewed in (each stage keeps the segments still to
//   be added) and sums de-skewed out (each stage keeps the segments already
//   done), so one aligned result appears S cycles after acceptance.
//
//   Parameters: N (width), S (stages, N % S == 0), TW (tag width)
//   Ports
//     i_clk, i_rst_n         clock, asynchronous active-low reset
//     i_valid / o_ready      input handshake
//     i_a, i_b, i_c, i_sub   operands, carry-in (add only), subtract select
//     i_tag                  caller tag, returned with the result
//     i_flush                kills every in-flight operation at the next edge
//     o_valid / i_ready      output handshake
//     o_s, o_c, o_ovf, o_tag result, carry-out (sub: 1 = no borrow),
//                            signed overflow, tag
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_adder_nbit
    import pipe_adder_nbit_pkg::*;
#(
    parameter int N  = 64,
    parameter int S  = 4,
    parameter int TW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  logic          i_c,
    input  logic          i_sub,
    input  logic [TW-1:0] i_tag,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_s,
    output logic          o_c,
    output logic          o_ovf,
    output logic [TW-1:0] o_tag
);

    localparam int W = seg_width(N, S);
    // Operand skew registers exist only for stages that still have segments
    // left to hand on; keep at least one entry so S == 1 elaborates.
    localparam int OPS = (S > 1) ? S - 1 : 1;

    if ((S < 1) || (S > N) || ((N % S) != 0)) begin : g_bad_params
        $error("pipe_adder_nbit: N must be a multiple of S with 1 <= S <= N");
    end

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    adder_mode_e  mode;
    logic [N-1:0] eff_b;
    logic         en;

    assign mode  = i_sub ? SUB : ADD;
    assign eff_b = (mode == SUB) ? ~i_b : i_b;

    // Lockstep pipeline: everything advances together or nothing moves.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic [S-1:0]  vld_q;
    logic [S-1:0]  vld_d;
    logic [S-1:0]  cry_q;
    logic [TW-1:0] tag_q [S];
    logic [N-1:0]  sum_q [S];
    logic [N-1:0]  opa_q [OPS];
    logic [N-1:0]  opb_q [OPS];
    logic          ovf_q;
    logic          ovf_d;

    // Per-stage values presented by the upstream side (port or stage k-1).
    logic [S-1:0]  up_vld;
    logic [S-1:0]  up_cin;
    logic [TW-1:0] up_tag [S];
    logic [N-1:0]  up_sum [S];
    logic [W-1:0]  seg_a  [S];
    logic [W-1:0]  seg_b  [S];
    logic [W-1:0]  seg_s  [S];
    logic [S-1:0]  seg_co;
    logic [S-1:0]  seg_ovf;
    logic [N-1:0]  sum_d  [S];
    logic [N-1:0]  opa_d  [OPS];
    logic [N-1:0]  opb_d  [OPS];
    logic [S-1:0]  ld;

    genvar gi;
    for (gi = 0; gi < S; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign up_vld[gi] = i_valid;
            assign up_tag[gi] = i_tag;
            assign up_sum[gi] = '0;
            assign up_cin[gi] = (mode == SUB) ? 1'b1 : i_c;
            assign seg_a[gi]  = i_a[W-1:0];
            assign seg_b[gi]  = eff_b[W-1:0];
        end else begin : g_body
            assign up_vld[gi] = vld_q[gi-1];
            assign up_tag[gi] = tag_q[gi-1];
            assign up_sum[gi] = sum_q[gi-1];
            assign up_cin[gi] = cry_q[gi-1];
            assign seg_a[gi]  = opa_q[gi-1][gi*W +: W];
            assign seg_b[gi]  = opb_q[gi-1][gi*W +: W];
        end

        pipe_add_seg #(
            .W       (W),
            .MSB_SEG (gi == S - 1)
        ) u_seg (
            .a    (seg_a[gi]),
            .b    (seg_b[gi]),
            .cin  (up_cin[gi]),
            .s    (seg_s[gi]),
            .cout (seg_co[gi]),
            .ovf  (seg_ovf[gi])
        );

        // Segments above k are still zero in the upstream partial sum, so
        // OR-ing the new segment into place is enough.
        assign sum_d[gi] = up_sum[gi] | (N'(seg_s[gi]) << (gi * W));

        if (gi < S - 1) begin : g_skew
            if (gi == 0) begin : g_skew_head
                assign opa_d[gi] = i_a;
                assign opb_d[gi] = eff_b;
            end else begin : g_skew_body
                assign opa_d[gi] = opa_q[gi-1];
                assign opb_d[gi] = opb_q[gi-1];
            end
        end
    end

    // Data registers only capture when real work arrives, which also keeps
    // the output registers frozen during a stall.
    assign ld = {S{en}} & up_vld;

    // Only the top segment drives a non-zero overflow term.
    assign ovf_d = |seg_ovf;

    always_comb begin
        vld_d = vld_q;
        if (i_flush) begin
            vld_d = '0;            // flush beats a same-cycle input transfer
        end else if (en) begin
            vld_d = up_vld;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < S; k++) begin
                tag_q[k] <= '0;
                sum_q[k] <= '0;
            end
            for (int k = 0; k < OPS; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < S; k++) begin
                if (ld[k]) begin
                    tag_q[k] <= up_tag[k];
                    cry_q[k] <= seg_co[k];
                    sum_q[k] <= sum_d[k];
                end
            end
            for (int k = 0; k < S - 1; k++) begin
                if (ld[k]) begin
                    opa_q[k] <= opa_d[k];
                    opb_q[k] <= opb_d[k];
                end
            end
            if (ld[S-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the last stage's registers.
    // ------------------------------------------------------------------
    assign o_valid = vld_q[S-1];
    assign o_s     = sum_q[S-1];
    assign o_c     = cry_q[S-1];
    assign o_ovf   = ovf_q;
    assign o_tag   = tag_q[S-1];

endmodule : pipe_adder_nbit
